// File: rtl/mcs4_pkg.sv
// Shared definitions for the MCS-4 RAM array: timing-phase indices, I/O opcodes, nibble type.
package mcs4_pkg;

    typedef logic [3:0] nibble_t;

    localparam int unsigned NPH  = 8;
    localparam int unsigned S_A1 = 0;
    localparam int unsigned S_A2 = 1;
    localparam int unsigned S_A3 = 2;
    localparam int unsigned S_M1 = 3;
    localparam int unsigned S_M2 = 4;
    localparam int unsigned S_X1 = 5;
    localparam int unsigned S_X2 = 6;
    localparam int unsigned S_X3 = 7;

    localparam nibble_t OPA_WRM = 4'b0000;
    localparam nibble_t OPA_WMP = 4'b0001;
    localparam nibble_t OPA_WRX = 4'b0100;
    localparam nibble_t OPA_SBM = 4'b1000;
    localparam nibble_t OPA_RDM = 4'b1001;
    localparam nibble_t OPA_ADM = 4'b1011;
    localparam nibble_t OPA_RDX = 4'b1100;

    function automatic logic is_main_rd(input nibble_t op);
        return (op == OPA_RDM) || (op == OPA_SBM) || (op == OPA_ADM);
    endfunction

    // WR0-3 and RD0-3 carry the status index in their low two bits
    function automatic logic is_stat_rd(input nibble_t op);
        return op[3:2] == OPA_RDX[3:2];
    endfunction

    function automatic logic is_stat_wr(input nibble_t op);
        return op[3:2] == OPA_WRX[3:2];
    endfunction

endpackage

// File: rtl/mcs4_ram_chip_core.sv
// One i4002-class chip: 4x16 main nibbles, 4x4 status nibbles, output port, access decode.
module mcs4_ram_chip_core
    import mcs4_pkg::*;
(
    input  logic       CLK,
    input  logic       reset,
    input  logic       i_ph_x1,
    input  logic       i_ph_x2,
    input  logic       i_sel,
    input  nibble_t    i_opa,
    input  logic [1:0] i_reg,
    input  nibble_t    i_char,
    input  nibble_t    i_wdata,
    input  logic       i_busy,
    input  logic [5:0] i_clr_addr,
    output nibble_t    o_rd_data,
    output logic       o_rd_vld,
    output nibble_t    o_port,
    output logic       o_port_wstb
);

    nibble_t    r_main [64];
    nibble_t    r_stat [16];
    nibble_t    r_rd_data;
    logic       r_rd_vld;
    nibble_t    r_port;
    logic       r_port_wstb;

    logic [5:0] w_main_addr;
    logic [3:0] w_stat_addr;
    logic       w_act;
    logic       w_rd_main;
    logic       w_rd_stat;
    logic       w_main_we;
    logic       w_stat_we;
    logic       w_port_we;

    assign w_main_addr = {i_reg, i_char};
    assign w_stat_addr = {i_reg, i_opa[1:0]};
    assign w_act       = i_sel & ~i_busy;
    assign w_rd_main   = is_main_rd(i_opa);
    assign w_rd_stat   = is_stat_rd(i_opa);
    assign w_main_we   = w_act & i_ph_x2 & (i_opa == OPA_WRM);
    assign w_stat_we   = w_act & i_ph_x2 & is_stat_wr(i_opa);
    assign w_port_we   = w_act & i_ph_x2 & (i_opa == OPA_WMP);

    // Storage arrays carry no reset; the clear engine owns them while busy
    always_ff @(posedge CLK) begin
        if (i_busy) begin
            r_main[i_clr_addr]      <= '0;
            r_stat[i_clr_addr[3:0]] <= '0;
        end else begin
            if (w_main_we) r_main[w_main_addr] <= i_wdata;
            if (w_stat_we) r_stat[w_stat_addr] <= i_wdata;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_rd_data   <= '0;
            r_rd_vld    <= 1'b0;
            r_port      <= '0;
            r_port_wstb <= 1'b0;
        end else begin
            r_port_wstb <= w_port_we;
            if (w_port_we) r_port <= i_wdata;
            if (i_ph_x1) begin
                r_rd_vld <= w_act & (w_rd_main | w_rd_stat);
                // Unselected chips hold zero so the top can OR all chips together
                if (w_act && w_rd_main)      r_rd_data <= r_main[w_main_addr];
                else if (w_act && w_rd_stat) r_rd_data <= r_stat[w_stat_addr];
                else                         r_rd_data <= '0;
            end
        end
    end

    assign o_rd_data   = r_rd_data;
    assign o_rd_vld    = r_rd_vld;
    assign o_port      = r_port;
    assign o_port_wstb = r_port_wstb;

endmodule

// File: rtl/mcs4_ram_array_gen.sv
// NBANK x NCHIP i4002-class RAM array: bus timing FSM, per-bank SRC/OPA snoop,
// post-reset clear engine and read-data OR-tree.
module mcs4_ram_array_gen
    import mcs4_pkg::*;
#(
    parameter int unsigned NBANK  = 8,
    parameter int unsigned NCHIP  = 4,
    parameter bit          CLR_EN = 1'b1
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     SYNC_N,
    input  logic [3:0]               DATA_I,
    output logic [3:0]               DATA_O,
    output logic                     DATA_OE,
    input  logic [NBANK-1:0]         CM_N,
    output logic [NBANK*NCHIP*4-1:0] PORT_OUT,
    output logic [NBANK*NCHIP-1:0]   PORT_WSTB,
    output logic                     CLR_BUSY,
    output logic                     SEL_MISS
);

    localparam int unsigned NCELL = NBANK * NCHIP;

    localparam logic [NPH-1:0] ST_STOP = 8'b0000_0000;
    localparam logic [NPH-1:0] ST_A1   = 8'b0000_0001;

    logic [NPH-1:0]          r_state;
    logic [NPH-1:0]          w_state_nxt;
    logic [NBANK-1:0][7:0]   r_src;
    logic [NBANK-1:0]        r_get;
    logic [NBANK-1:0][4:0]   r_opa;
    logic [5:0]              r_clr_cnt;
    logic                    r_clr_busy;
    logic                    r_sel_miss;
    logic                    w_miss;
    nibble_t [NCELL-1:0]     w_rd_data;
    logic [NCELL-1:0]        w_rd_vld;
    nibble_t                 w_rd_or;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) r_state <= ST_STOP;
        else        r_state <= w_state_nxt;
    end

    // SYNC_N forces A1; otherwise rotate, and X3 without SYNC_N drops to STOP
    always_comb begin
        w_state_nxt = ST_STOP;
        if (!SYNC_N) begin
            w_state_nxt = ST_A1;
        end else begin
            w_state_nxt[S_A2] = r_state[S_A1];
            w_state_nxt[S_A3] = r_state[S_A2];
            w_state_nxt[S_M1] = r_state[S_A3];
            w_state_nxt[S_M2] = r_state[S_M1];
            w_state_nxt[S_X1] = r_state[S_M2];
            w_state_nxt[S_X2] = r_state[S_X1];
            w_state_nxt[S_X3] = r_state[S_X2];
        end
    end

    // Per-bank SRC address and OPA snoop; opa[4] marks an I/O op aimed at this bank
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_src <= '0;
            r_get <= '0;
            r_opa <= '0;
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                if (r_state[S_X2] && !CM_N[b]) begin
                    r_src[b][7:4] <= DATA_I;
                    r_get[b]      <= 1'b1;
                end else if (r_state[S_X3] && r_get[b]) begin
                    r_src[b][3:0] <= DATA_I;
                    r_get[b]      <= 1'b0;
                end
                if (r_state[S_M2] && !CM_N[b]) r_opa[b] <= {1'b1, DATA_I};
                else if (r_state[S_X3])        r_opa[b] <= '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_clr_cnt  <= '0;
            r_clr_busy <= CLR_EN;
        end else if (r_clr_busy) begin
            r_clr_cnt <= r_clr_cnt + 6'd1;
            if (r_clr_cnt == 6'd63) r_clr_busy <= 1'b0;
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        for (genvar c = 0; c < NCHIP; c++) begin : g_chip
            localparam int unsigned IDX = 32'(b) * NCHIP + 32'(c);
            mcs4_ram_chip_core u_core (
                .CLK         (CLK),
                .reset       (reset),
                .i_ph_x1     (r_state[S_X1]),
                .i_ph_x2     (r_state[S_X2]),
                .i_sel       (r_opa[b][4] && (r_src[b][7:6] == 2'(c))),
                .i_opa       (r_opa[b][3:0]),
                .i_reg       (r_src[b][5:4]),
                .i_char      (r_src[b][3:0]),
                .i_wdata     (DATA_I),
                .i_busy      (r_clr_busy),
                .i_clr_addr  (r_clr_cnt),
                .o_rd_data   (w_rd_data[IDX]),
                .o_rd_vld    (w_rd_vld[IDX]),
                .o_port      (PORT_OUT[IDX*4 +: 4]),
                .o_port_wstb (PORT_WSTB[IDX])
            );
        end
    end

    // An unpopulated chip id only exists when a bank has fewer than four chips
    if (NCHIP < 4) begin : g_miss
        always_comb begin
            w_miss = 1'b0;
            for (int b = 0; b < NBANK; b++) begin
                if (r_opa[b][4] && (r_src[b][7:6] >= 2'(NCHIP))) w_miss = 1'b1;
            end
        end
    end else begin : g_nomiss
        assign w_miss = 1'b0;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) r_sel_miss <= 1'b0;
        else        r_sel_miss <= r_state[S_X2] & w_miss;
    end

    always_comb begin
        w_rd_or = '0;
        for (int i = 0; i < NCELL; i++) w_rd_or = w_rd_or | w_rd_data[i];
    end

    // Bus drive is combinational and confined to X2
    assign DATA_OE  = r_state[S_X2] & (|w_rd_vld);
    assign DATA_O   = DATA_OE ? w_rd_or : 4'h0;
    assign CLR_BUSY = r_clr_busy;
    assign SEL_MISS = r_sel_miss;

endmodule

// File: tb/tb_mcs4_ram_array_gen.sv
// Directed bench for mcs4_ram_array_gen: an 8x4 array plus a 2x2 array sharing the bus.
module tb_mcs4_ram_array_gen;
    import mcs4_pkg::*;

    localparam int unsigned NB = 8, NC = 4, NB2 = 2, NC2 = 2;

    logic                 CLK = 1'b0;
    logic                 reset = 1'b0;
    logic                 SYNC_N = 1'b1;
    logic [3:0]           DATA_I = 4'h0;
    logic [NB-1:0]        CM_N = '1;
    logic [NB2-1:0]       CM2_N = '1;
    logic [3:0]           DATA_O, DATA2_O;
    logic                 DATA_OE, DATA2_OE;
    logic [NB*NC*4-1:0]   PORT_OUT;
    logic [NB2*NC2*4-1:0] PORT2_OUT;
    logic [NB*NC-1:0]     PORT_WSTB;
    logic [NB2*NC2-1:0]   PORT2_WSTB;
    logic                 CLR_BUSY, CLR2_BUSY, SEL_MISS, SEL2_MISS;

    mcs4_ram_array_gen #(.NBANK(NB), .NCHIP(NC), .CLR_EN(1'b1)) dut (
        .CLK(CLK), .reset(reset), .SYNC_N(SYNC_N), .DATA_I(DATA_I),
        .DATA_O(DATA_O), .DATA_OE(DATA_OE), .CM_N(CM_N),
        .PORT_OUT(PORT_OUT), .PORT_WSTB(PORT_WSTB),
        .CLR_BUSY(CLR_BUSY), .SEL_MISS(SEL_MISS)
    );

    mcs4_ram_array_gen #(.NBANK(NB2), .NCHIP(NC2), .CLR_EN(1'b1)) dut2 (
        .CLK(CLK), .reset(reset), .SYNC_N(SYNC_N), .DATA_I(DATA_I),
        .DATA_O(DATA2_O), .DATA_OE(DATA2_OE), .CM_N(CM2_N),
        .PORT_OUT(PORT2_OUT), .PORT_WSTB(PORT2_WSTB),
        .CLR_BUSY(CLR2_BUSY), .SEL_MISS(SEL2_MISS)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int busy_cnt = 0;

    always @(posedge CLK) if (reset && CLR_BUSY) busy_cnt++;

    logic           s_oe_x2, s_oe_other, s_miss_x3, s_miss_other, s_wstb_other;
    logic [3:0]     s_do_x2, s2_do_x2;
    logic           s2_oe_x2, s2_miss_x3, s2_miss_other;
    logic [NB*NC-1:0] s_wstb_x3;

    typedef struct {
        logic [7:0] cm_n;
        logic [7:0] src;
        nibble_t    op;
        nibble_t    wd;
        logic       exp_oe;
        nibble_t    exp_do;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One 8-phase instruction cycle; entered and left just after the A1 edge
    task automatic bus_cycle(input logic [NB-1:0] m2_cm, input logic [NB2-1:0] m2_cm2,
                             input nibble_t m2_d, input logic [NB-1:0] x2_cm,
                             input logic [NB2-1:0] x2_cm2, input nibble_t x2_d,
                             input nibble_t x3_d, input logic stop);
        s_oe_x2 = 0; s_do_x2 = 0; s_oe_other = 0; s_miss_x3 = 0; s_miss_other = 0;
        s_wstb_x3 = '0; s_wstb_other = 0; s2_oe_x2 = 0; s2_do_x2 = 0;
        s2_miss_x3 = 0; s2_miss_other = 0;
        for (int p = 0; p < 8; p++) begin
            SYNC_N = (p == 7 && !stop) ? 1'b0 : 1'b1;
            CM_N   = (p == 4) ? m2_cm  : (p == 6) ? x2_cm  : '1;
            CM2_N  = (p == 4) ? m2_cm2 : (p == 6) ? x2_cm2 : '1;
            DATA_I = (p == 4) ? m2_d : (p == 6) ? x2_d : (p == 7) ? x3_d : 4'h0;
            @(negedge CLK);
            if (p == 6) begin
                s_oe_x2 = DATA_OE; s_do_x2 = DATA_O; s2_oe_x2 = DATA2_OE; s2_do_x2 = DATA2_O;
            end else if (DATA_OE || DATA2_OE) begin
                s_oe_other = 1;
            end
            if (p == 7) begin
                s_miss_x3 = SEL_MISS; s2_miss_x3 = SEL2_MISS; s_wstb_x3 = PORT_WSTB;
            end else begin
                if (SEL_MISS) s_miss_other = 1;
                if (SEL2_MISS) s2_miss_other = 1;
                if (|PORT_WSTB) s_wstb_other = 1;
            end
            @(posedge CLK); #1;
        end
        SYNC_N = 1'b1; CM_N = '1; CM2_N = '1; DATA_I = 4'h0;
    endtask

    task automatic src_cycle(input logic [NB-1:0] cm, input logic [NB2-1:0] cm2, input logic [7:0] src);
        bus_cycle('1, '1, 4'h0, cm, cm2, src[7:4], src[3:0], 1'b0);
    endtask

    task automatic io_cycle(input logic [NB-1:0] cm, input logic [NB2-1:0] cm2,
                            input nibble_t op, input nibble_t wd, input logic stop);
        bus_cycle(cm, cm2, op, '1, '1, wd, 4'h0, stop);
    endtask

    task automatic sync_start;
        SYNC_N = 1'b0;
        @(posedge CLK); #1;
        SYNC_N = 1'b1;
    endtask

    task automatic wait_busy_low(output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (!CLR_BUSY) begin ok = 1; break; end
            @(negedge CLK);
        end
    endtask

    initial begin
        bit ok;
        logic flag;

        vt[0]  = '{8'h7F, 8'h33, OPA_RDM, 4'h0, 1'b1, 4'h0};
        vt[1]  = '{8'hFB, 8'h5A, OPA_WRM, 4'hC, 1'b0, 4'h0};
        vt[2]  = '{8'hFB, 8'h5A, OPA_RDM, 4'h0, 1'b1, 4'hC};
        vt[3]  = '{8'hFB, 8'h1A, OPA_RDM, 4'h0, 1'b1, 4'h0};
        vt[4]  = '{8'hF7, 8'h5A, OPA_RDM, 4'h0, 1'b1, 4'h0};
        vt[5]  = '{8'hFB, 8'hF0, 4'b0110, 4'h7, 1'b0, 4'h0};
        vt[6]  = '{8'hFB, 8'hF0, 4'b1110, 4'h0, 1'b1, 4'h7};
        vt[7]  = '{8'hFB, 8'hF0, 4'b1101, 4'h0, 1'b1, 4'h0};
        vt[8]  = '{8'hFB, 8'hF0, 4'b1111, 4'h0, 1'b1, 4'h0};
        vt[9]  = '{8'hFB, 8'h5A, OPA_SBM, 4'h0, 1'b1, 4'hC};
        vt[10] = '{8'hFB, 8'h5A, OPA_ADM, 4'h0, 1'b1, 4'hC};
        vt[11] = '{8'hEF, 8'h5A, OPA_WRM, 4'h3, 1'b0, 4'h0};
        vt[12] = '{8'hEB, 8'h5A, OPA_RDM, 4'h0, 1'b1, 4'hF};
        vt[13] = '{8'h9F, 8'h22, OPA_WRM, 4'h6, 1'b0, 4'h0};
        vt[14] = '{8'hDF, 8'h22, OPA_RDM, 4'h0, 1'b1, 4'h6};
        vt[15] = '{8'hBF, 8'h22, OPA_RDM, 4'h0, 1'b1, 4'h6};

        // Reset values
        @(negedge CLK); @(negedge CLK);
        chk("rst_data_oe", DATA_OE, 0);
        chk("rst_data_o", DATA_O, 0);
        chk("rst_port_out", PORT_OUT, 0);
        chk("rst_port_wstb", PORT_WSTB, 0);
        chk("rst_sel_miss", SEL_MISS, 0);
        chk("rst_clr_busy", CLR_BUSY, 1);

        // Clear sweep after release
        reset = 1'b1; busy_cnt = 0;
        chk("busy_after_release", CLR_BUSY, 1);
        wait_busy_low(ok);
        chk("busy_timeout", ok, 1);
        chk("busy_cycles", busy_cnt, 64);
        chk("small_busy_done", CLR2_BUSY, 0);

        sync_start();
        for (int i = 0; i < 16; i++) begin
            src_cycle(vt[i].cm_n, '1, vt[i].src);
            io_cycle(vt[i].cm_n, '1, vt[i].op, vt[i].wd, 1'b0);
            chk($sformatf("vec%0d_oe", i), s_oe_x2, vt[i].exp_oe);
            chk($sformatf("vec%0d_data", i), s_do_x2, vt[i].exp_do);
            chk($sformatf("vec%0d_oe_outside_x2", i), s_oe_other, 0);
        end

        // WMP to bank 0 chip 2
        src_cycle(8'hFE, '1, 8'h80);
        io_cycle(8'hFE, '1, OPA_WMP, 4'h9, 1'b0);
        chk("wmp_port_out", PORT_OUT, 128'h900);
        chk("wmp_wstb_x3", s_wstb_x3, 32'h4);
        chk("wmp_wstb_other", s_wstb_other, 0);
        @(negedge CLK);
        chk("wmp_wstb_after", PORT_WSTB, 0);
        @(posedge CLK); #1;
        sync_start();

        // Unpopulated chip id on the 2x2 array
        src_cycle('1, 2'b10, 8'hC0);
        io_cycle('1, 2'b10, OPA_RDM, 4'h0, 1'b0);
        chk("miss_oe", s2_oe_x2, 0);
        chk("miss_pulse", s2_miss_x3, 1);
        chk("miss_other", s2_miss_other, 0);
        chk("miss_main_quiet", s_miss_x3, 0);
        src_cycle('1, 2'b10, 8'h40);
        io_cycle('1, 2'b10, OPA_RDM, 4'h0, 1'b0);
        chk("small_hit_oe", s2_oe_x2, 1);
        chk("small_hit_data", s2_do_x2, 0);
        chk("small_hit_nomiss", s2_miss_x3, 0);
        chk("small_port_out", PORT2_OUT, 0);
        chk("small_port_wstb", PORT2_WSTB, 0);

        // FSM stop when SYNC_N stays high after X3
        src_cycle(8'hFB, '1, 8'h5A);
        io_cycle(8'hFB, '1, OPA_RDM, 4'h0, 1'b1);
        chk("stop_last_read", s_do_x2, 4'hC);
        flag = 0;
        CM_N = 8'hFB; DATA_I = OPA_RDM;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            if (DATA_OE) flag = 1;
        end
        chk("stop_no_oe", flag, 0);
        CM_N = '1; DATA_I = 4'h0;
        @(posedge CLK); #1;
        sync_start();
        io_cycle(8'hFB, '1, OPA_RDM, 4'h0, 1'b0);
        chk("resync_oe", s_oe_x2, 1);
        chk("resync_data", s_do_x2, 4'hC);

        // Reset mid-sweep, then a write during busy must be ignored
        @(negedge CLK);
        reset = 1'b0;
        #1;
        chk("rst2_clr_busy", CLR_BUSY, 1);
        chk("rst2_port_out", PORT_OUT, 0);
        @(negedge CLK);
        reset = 1'b1; busy_cnt = 0;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy_cnt == 30) begin ok = 1; break; end
            @(negedge CLK);
        end
        chk("cnt30_reached", ok, 1);
        reset = 1'b0;
        @(negedge CLK);
        reset = 1'b1; busy_cnt = 0;
        sync_start();
        src_cycle(8'hFD, '1, 8'h00);
        io_cycle(8'hFD, '1, OPA_WRM, 4'hF, 1'b0);
        chk("busy_during_wrm", CLR_BUSY, 1);
        wait_busy_low(ok);
        chk("busy2_timeout", ok, 1);
        chk("busy2_cycles", busy_cnt, 64);
        sync_start();
        src_cycle(8'hFD, '1, 8'h00);
        io_cycle(8'hFD, '1, OPA_RDM, 4'h0, 1'b0);
        chk("busy_wrm_oe", s_oe_x2, 1);
        chk("busy_wrm_ignored", s_do_x2, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
